// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit, one radix-2 step per cycle.
// Constant XLEN-cycle latency for every op; flush aborts, rst returns to idle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready=1
  // CALC  | one shift-add / shift-subtract step per cycle
  // DONE  | result presented until consumed or flushed
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_q, neg_rem_q, div_zero_q;
  logic [XLEN:0]   acc, acc_nx;
  logic [XLEN-1:0] lo, lo_nx;
  logic [XLEN:0]   mcand;

  logic            accept, last;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]   a_mag, b_mag;

  logic [XLEN:0]     sum, shifted;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign last      = (cnt == CW'(XLEN-1));

  // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MUL/MULH/DIV/REM treat rs2 as signed
  assign a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign b_signed = op[2] ? ~op[0] : ~op[1];
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -{1'b1, a} : {1'b0, a};
  assign b_mag    = b_neg ? -{1'b1, b} : {1'b0, b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (flush) state_nx = IDLE;
               else if (last) state_nx = DONE;
      DONE:    if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiply: {acc, lo} shifts right with the multiplier consumed from lo[0].
  // Divide: {acc, lo} shifts left, quotient bits enter lo[0].
  always_comb begin
    acc_nx  = acc;
    lo_nx   = lo;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (op_q[2]) begin
      shifted = {acc[XLEN-1:0], lo[XLEN-1]};
      diff    = {1'b0, shifted} - {1'b0, mcand};
      acc_nx  = diff[XLEN+1] ? shifted : diff[XLEN:0];
      lo_nx   = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      sum    = acc + (lo[0] ? mcand : '0);
      acc_nx = {1'b0, sum[XLEN:1]};
      lo_nx  = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {acc_nx[XLEN-1:0], lo_nx};
    prod_s = neg_q ? -prod : prod;
    quot_s = div_zero_q ? '1 : (neg_q ? -lo_nx : lo_nx);
    rem_s  = neg_rem_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    if (!op_q[2])
      res_fin = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      res_fin = op_q[1] ? rem_s : quot_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc        <= '0;
      lo         <= '0;
      mcand      <= '0;
      result     <= '0;
      zero       <= 1'b1;
    end else if (accept) begin
      cnt        <= '0;
      op_q       <= op;
      neg_q      <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (b == '0);
      acc        <= '0;
      lo         <= op[2] ? a_mag[XLEN-1:0] : b_mag[XLEN-1:0];
      mcand      <= op[2] ? b_mag : a_mag;
    end else if (state == CALC && !flush) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        result <= res_fin;
        zero   <= (res_fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corners, random ops against an
// arithmetic reference model, backpressure, flush and reset, plus an XLEN=8 instance.
module tb_muldiv_unit;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1, zero;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0, result;

  logic        in_valid8 = 0, in_ready8, flush8 = 0, out_valid8, out_ready8 = 1, zero8;
  logic [2:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, result8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-/zero-extended operands of width w (<=32).
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                            input logic [31:0] x, input logic [31:0] y);
    longint mask, xu, yu, xs, ys, p, r;
    mask = (longint'(1) << w) - 1;
    xu = longint'(x) & mask;
    yu = longint'(y) & mask;
    xs = x[w-1] ? xu - (longint'(1) << w) : xu;
    ys = y[w-1] ? yu - (longint'(1) << w) : yu;
    case (f)
      3'd0: r = xu * yu;
      3'd1: begin p = xs * ys; r = p >>> w; end
      3'd2: begin p = xs * yu; r = p >>> w; end
      3'd3: begin p = xu * yu; r = p >> w; end
      3'd4: if (yu == 0) r = -1;
            else if (xs == -(longint'(1) << (w-1)) && ys == -1) r = xs;
            else r = xs / ys;
      3'd5: r = (yu == 0) ? -1 : xu / yu;
      3'd6: if (yu == 0) r = xs;
            else if (xs == -(longint'(1) << (w-1)) && ys == -1) r = 0;
            else r = xs % ys;
      default: r = (yu == 0) ? xu : xu % yu;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic run32(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " ready"}, in_ready, 1);
    in_valid = 1; op = f; a = x; b = y; out_ready = 1;
    @(negedge clk);
    in_valid = 0; op = 3'($urandom); a = $urandom; b = $urandom;
    chk({tag, " busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, " lat"}, n, 32);
    chk({tag, " res"}, result, exp);
    chk({tag, " zero"}, zero, exp == 0);
  endtask

  task automatic run8(input string tag, input logic [2:0] f, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] exp);
    int n = 0;
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    chk({tag, " ready"}, in_ready8, 1);
    in_valid8 = 1; op8 = f; a8 = x; b8 = y; out_ready8 = 1;
    @(negedge clk);
    in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!out_valid8 && n < 100) begin @(negedge clk); n++; end
    chk({tag, " lat"}, n, 8);
    chk({tag, " res"}, result8, exp);
    chk({tag, " zero"}, zero8, exp == 0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct { logic [2:0] f; logic [31:0] x, y, exp; } vec_t;
  vec_t dir[] = '{
    '{3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF},
    '{3'd5, 32'h7,        32'h2,        32'h3},
    '{3'd7, 32'h7,        32'h2,        32'h1},
    '{3'd6, 32'h6,        32'h3,        32'h0},
    '{3'd4, 32'h5,        32'h0,        32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF},
    '{3'd6, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9},
    '{3'd5, 32'h5,        32'h0,        32'hFFFFFFFF},
    '{3'd7, 32'h5,        32'h0,        32'h5},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0}
  };

  initial begin
    logic [31:0] x, y;
    logic [2:0]  f;
    logic        seen;
    int          n;

    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst result", result, 0);
    chk("rst zero", zero, 1);
    rst = 0;
    @(negedge clk);

    // reset in the middle of a multiply
    in_valid = 1; op = 0; a = 3; b = 5;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst result", result, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run32("mul after rst", 3'd0, 32'd3, 32'd5, 32'd15);

    foreach (dir[i]) run32($sformatf("dir%0d", i), dir[i].f, dir[i].x, dir[i].y, dir[i].exp);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom); x = pick32(); y = pick32();
      run32($sformatf("rnd%0d op%0d %h %h", i, f, x, y), f, x, y, ref_model(32, f, x, y));
    end

    // backpressure: result held, stray in_valid ignored, accept one cycle after consume
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1; op = 3'd4; a = 100; b = 7; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp lat", n, 32);
    chk("bp res", result, 14);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; op = 3'd0; a = $urandom; b = $urandom;
      @(negedge clk);
      chk($sformatf("bp hold%0d", i), {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd14});
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp consumed", {out_valid, in_ready}, 2'b01);
    in_valid = 1; op = 3'd7; a = 100; b = 7;
    @(negedge clk);
    in_valid = 0;
    chk("bp next accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp2 lat", n, 32);
    chk("bp2 res", result, 2);

    // flush during CALC
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1; op = 3'd0; a = 3; b = 5;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flcalc state", {out_valid, in_ready}, 2'b01);
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    chk("flcalc no result", seen, 0);

    // flush in DONE with out_ready high
    in_valid = 1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("fldone lat", n, 32);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fldone state", {out_valid, in_ready}, 2'b01);

    // flush in IDLE drops a concurrent request
    in_valid = 1; flush = 1; op = 3'd0; a = 3; b = 5;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("flidle in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    chk("flidle no result", seen, 0);
    run32("after flush", 3'd5, 32'd1000, 32'd10, 32'd100);

    // XLEN=8 instance
    run8("x8 mulhu", 3'd3, 8'hFF, 8'hFF, 8'hFE);
    run8("x8 div ovf", 3'd4, 8'h80, 8'hFF, 8'h80);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom); x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(0, 255));
      if (i % 8 == 0) y = 0;
      run8($sformatf("x8 rnd%0d op%0d %h %h", i, f, x[7:0], y[7:0]), f, x[7:0], y[7:0],
           8'(ref_model(8, f, x, y)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
